// File: rtl/imem_loader_if.sv
// Bundles the loader's control, byte-stream and IMEM write signals.
// The host/debug side is the master; the loader is the slave.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, load_len, abort, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, busy, done, err
    );

    modport slave (
        input  start, load_len, abort, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Streams bytes from the host link into IMEM as little-endian 32-bit words,
// starting at word 0, while holding the CPU so no half-written program runs.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] word_next;
    logic [1:0]      byte_cnt;
    logic [31:0]     asm_word;
    logic            busy_q;
    logic            hold_q;
    logic            done_q;
    logic            err_q;
    logic            len_ok;
    logic            byte_ready_i;
    logic            byte_fire;

    // Abort wins over a byte arriving in the same cycle, so it never counts as accepted.
    assign byte_ready_i = (state == RECV) && !bus.abort;
    assign byte_fire    = byte_ready_i && bus.byte_valid;
    assign word_next    = word_cnt + 1'b1;
    assign len_ok       = (bus.load_len != '0) && (bus.load_len <= DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values of the others.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            len      <= bus.load_len;
                            word_cnt <= '0;
                            byte_cnt <= '0;
                            asm_word <= '0;
                            busy_q   <= 1'b1;
                            hold_q   <= 1'b1;
                            state    <= RECV;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (bus.abort) begin
                        byte_cnt <= '0;
                        asm_word <= '0;
                        busy_q   <= 1'b0;
                        hold_q   <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= IDLE;
                    end else if (byte_fire) begin
                        asm_word[{byte_cnt, 3'b000} +: 8] <= bus.byte_in;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (bus.abort) begin
                        byte_cnt <= '0;
                        asm_word <= '0;
                        busy_q   <= 1'b0;
                        hold_q   <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        word_cnt <= word_next;
                        byte_cnt <= '0;
                        if (word_next == len) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= RECV;
                        end
                    end
                end

                DONE: begin
                    busy_q <= 1'b0;
                    hold_q <= 1'b0;
                    state  <= IDLE;
                    if (bus.abort) begin
                        err_q <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // The strobe is decoded from state so an abort in WRITE can still cancel it.
    assign bus.byte_ready = byte_ready_i;
    assign bus.imem_we    = (state == WRITE) && !bus.abort;
    assign bus.imem_addr  = word_cnt[ADDR_W-1:0];
    assign bus.imem_wdata = asm_word;
    assign bus.cpu_hold   = hold_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 10-bit-address instance for most cases and a
// 4-bit-address instance for the full-depth load.
module tb_imem_loader;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        abort;
    logic        start10;
    logic        start4;
    logic [10:0] len10;
    logic [4:0]  len4;
    bit          sel;

    always #(PERIOD / 2) clk = ~clk;

    imem_loader_if #(.ADDR_W(10)) b10 ();
    imem_loader_if #(.ADDR_W(4))  b4 ();

    assign b10.start      = start10;
    assign b10.load_len   = len10;
    assign b10.abort      = abort;
    assign b10.byte_in    = byte_in;
    assign b10.byte_valid = byte_valid;
    assign b4.start       = start4;
    assign b4.load_len    = len4;
    assign b4.abort       = abort;
    assign b4.byte_in     = byte_in;
    assign b4.byte_valid  = byte_valid;

    imem_loader #(.ADDR_W(10)) dut10 (.clk(clk), .rst(rst), .bus(b10));
    imem_loader #(.ADDR_W(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitors sample on the falling edge; stimulus changes 1 time unit after the rising edge.
    logic [41:0] wq10[$];
    logic [35:0] wq4[$];
    int  done10 = 0;
    int  err10  = 0;
    int  hold10 = 0;
    int  done4  = 0;
    bit  overlap = 1'b0;
    time t_done = 0;
    time t_acc  = 0;
    bit  first_seen;

    always @(negedge clk) begin
        if (b10.imem_we) wq10.push_back({b10.imem_addr, b10.imem_wdata});
        if (b4.imem_we)  wq4.push_back({b4.imem_addr, b4.imem_wdata});
        if (b10.done) begin
            done10++;
            t_done = $time;
        end
        if (b10.err)      err10++;
        if (b10.cpu_hold) hold10++;
        if (b4.done)      done4++;
        if ((b10.done && b10.err) || (b4.done && b4.err)) overlap = 1'b1;
    end

    function automatic logic cur_ready();
        return sel ? b4.byte_ready : b10.byte_ready;
    endfunction

    function automatic logic cur_busy();
        return sel ? b4.busy : b10.busy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit s, input int len);
        if (s) begin
            start4 = 1'b1;
            len4   = len[4:0];
        end else begin
            start10 = 1'b1;
            len10   = len[10:0];
        end
        tick();
        start4  = 1'b0;
        start10 = 1'b0;
    endtask

    // Presents one byte and holds it until the selected loader accepts it.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (cur_ready()) begin
                ok = 1'b1;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    t_acc      = $time;
                end
            end
            tick();
        end
        if (!ok) check("byte_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!cur_busy()) ok = 1'b1;
        end
        if (!ok) check(tag, 0, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  basic_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        logic [6:0]  gap_pat = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
        logic [7:0]  gap_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int k;
        int d0;
        int e0;
        int h0;

        rst        = 1'b1;
        byte_in    = '0;
        byte_valid = 1'b0;
        abort      = 1'b0;
        start10    = 1'b0;
        start4     = 1'b0;
        len10      = '0;
        len4       = '0;
        sel        = 1'b0;
        #3;
        check("reset_outputs", {b10.busy, b10.cpu_hold, b10.done, b10.err, b10.imem_we, b10.byte_ready}, 6'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic two-word load with valid held high.
        wq10.delete();
        d0 = done10;
        h0 = hold10;
        first_seen = 1'b0;
        pulse_start(0, 2);
        foreach (basic_bytes[i]) send_byte(basic_bytes[i]);
        byte_valid = 1'b0;
        wait_idle("basic_idle_timeout");
        check("basic_write_count", wq10.size(), 2);
        if (wq10.size() >= 2) begin
            check("basic_word0", wq10[0], {10'd0, 32'h0000_0013});
            check("basic_word1", wq10[1], {10'd1, 32'h0010_0093});
        end
        check("basic_done_count", done10 - d0, 1);
        check("basic_first_byte_to_done_cycles", (t_done - t_acc) / PERIOD + 1, 11);
        check("basic_hold_cycles", hold10 - h0, 11);
        check("basic_hold_released", b10.cpu_hold, 0);

        // Gapped stream: valid pattern 1,0,0,1,1,0,1.
        wq10.delete();
        pulse_start(0, 1);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            byte_valid = gap_pat[i];
            byte_in    = gap_pat[i] ? gap_bytes[k] : 8'h5A;
            if (gap_pat[i]) k++;
            tick();
        end
        byte_valid = 1'b0;
        wait_idle("gap_idle_timeout");
        check("gap_write_count", wq10.size(), 1);
        if (wq10.size() >= 1) check("gap_word0", wq10[0], {10'd0, 32'hDEAD_BEEF});

        // Illegal lengths: zero and one past the depth.
        wq10.delete();
        e0 = err10;
        pulse_start(0, 0);
        @(negedge clk);
        check("len0_err_busy_hold", {b10.err, b10.busy, b10.cpu_hold}, 3'b100);
        tick();
        pulse_start(0, 1025);
        @(negedge clk);
        check("len1025_err_busy_hold", {b10.err, b10.busy, b10.cpu_hold}, 3'b100);
        tick();
        tick();
        check("badlen_err_count", err10 - e0, 2);
        check("badlen_no_write", wq10.size(), 0);

        // Full depth on the 16-word instance.
        sel = 1'b1;
        wq4.delete();
        d0 = done4;
        pulse_start(1, 16);
        for (int w = 0; w < 16; w++) begin
            for (int j = 0; j < 4; j++) send_byte(w[7:0]);
        end
        byte_valid = 1'b0;
        wait_idle("full_idle_timeout");
        repeat (5) tick();
        check("full_write_count", wq4.size(), 16);
        for (int w = 0; w < 16 && w < wq4.size(); w++) begin
            check($sformatf("full_word%0d", w), wq4[w], {w[3:0], w[31:0] * 32'h0101_0101});
        end
        check("full_done_count", done4 - d0, 1);
        pulse_start(1, 17);
        @(negedge clk);
        check("len17_err_busy", {b4.err, b4.busy}, 2'b10);
        tick();
        sel = 1'b0;

        // Abort after six bytes of a three-word load.
        wq10.delete();
        d0 = done10;
        e0 = err10;
        pulse_start(0, 3);
        for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11));
        byte_in = 8'h77;
        abort   = 1'b1;
        @(negedge clk);
        check("abort_ready_forced_low", b10.byte_ready, 0);
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check("abort_err_busy", {b10.err, b10.busy}, 2'b10);
        tick();
        check("abort_write_count", wq10.size(), 1);
        if (wq10.size() >= 1) check("abort_word0", wq10[0], {10'd0, 32'h4433_2211});
        check("abort_no_done", done10 - d0, 0);
        check("abort_err_count", err10 - e0, 1);
        pulse_start(0, 1);
        foreach (basic_bytes[i]) if (i < 4) send_byte(8'hA1 + 8'(i * 8'h11));
        byte_valid = 1'b0;
        wait_idle("reload_idle_timeout");
        check("reload_write_count", wq10.size(), 2);
        if (wq10.size() >= 2) check("reload_word0", wq10[1], {10'd0, 32'hD4C3_B2A1});

        // Abort landing on the write cycle cancels the strobe.
        wq10.delete();
        d0 = done10;
        pulse_start(0, 1);
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("abort_write_we_suppressed", b10.imem_we, 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_write_err_busy", {b10.err, b10.busy}, 2'b10);
        tick();
        check("abort_write_no_write", wq10.size(), 0);
        check("abort_write_no_done", done10 - d0, 0);

        // Asynchronous reset between edges, two bytes into word 1.
        wq10.delete();
        d0 = done10;
        e0 = err10;
        pulse_start(0, 2);
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
        byte_valid = 1'b1;
        byte_in    = 8'h36;
        check("pre_reset_busy", b10.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {b10.busy, b10.cpu_hold, b10.done, b10.err, b10.imem_we, b10.byte_ready}, 6'b0);
        byte_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("reset_write_count", wq10.size(), 1);
        check("reset_no_done_no_err", {done10 - d0, err10 - e0}, 64'd0);
        pulse_start(0, 1);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
        byte_valid = 1'b0;
        wait_idle("post_reset_idle_timeout");
        check("post_reset_write_count", wq10.size(), 2);
        if (wq10.size() >= 2) check("post_reset_word0", wq10[1], {10'd0, 32'h0403_0201});

        check("done_err_never_together", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
